// File: rtl/ex_operand_stage.sv
// ID->EX pipeline register with MEM/WB operand forwarding and load-use hazard detection.
// Drives ALU operands combinationally from the EX slot; handles stall (hold) and flush (bubble).
module ex_operand_stage #(
  parameter int                 XLEN    = 32,
  parameter int                 ALUOP_W = 4,
  parameter logic [ALUOP_W-1:0] ALU_XXX = '1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid_i,
  input  logic [XLEN-1:0]    id_pc_i,
  input  logic [4:0]         id_rs1_i,
  input  logic [4:0]         id_rs2_i,
  input  logic               id_rs1_used_i,
  input  logic               id_rs2_used_i,
  input  logic [XLEN-1:0]    id_rs1_data_i,
  input  logic [XLEN-1:0]    id_rs2_data_i,
  input  logic [XLEN-1:0]    id_imm_i,
  input  logic [1:0]         id_a_sel_i,
  input  logic [1:0]         id_b_sel_i,
  input  logic [ALUOP_W-1:0] id_alu_op_i,
  input  logic [4:0]         id_rd_i,
  input  logic               id_we_i,
  input  logic               id_is_load_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               mem_we_i,
  input  logic [4:0]         mem_rd_i,
  input  logic [XLEN-1:0]    mem_data_i,
  input  logic               wb_we_i,
  input  logic [4:0]         wb_rd_i,
  input  logic [XLEN-1:0]    wb_data_i,
  output logic [XLEN-1:0]    alu_a_o,
  output logic [XLEN-1:0]    alu_b_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               ex_valid_o,
  output logic [4:0]         ex_rd_o,
  output logic               ex_we_o,
  output logic               ex_is_load_o,
  output logic [XLEN-1:0]    ex_pc_o,
  output logic [XLEN-1:0]    ex_store_data_o,
  output logic               load_use_stall_o
);

  logic                     valid_q, valid_d;
  logic                     we_q, we_d;
  logic                     is_load_q, is_load_d;
  logic [4:0]               rd_q, rd_d;
  logic [XLEN-1:0]          pc_q, pc_d;
  logic [XLEN-1:0]          imm_q, imm_d;
  logic [1:0]               a_sel_q, a_sel_d;
  logic [1:0]               b_sel_q, b_sel_d;
  logic [ALUOP_W-1:0]       alu_op_q, alu_op_d;
  // Index 0 is rs1, index 1 is rs2.
  logic [1:0][4:0]          rs_q, rs_d;
  logic [1:0][XLEN-1:0]     rs_data_q, rs_data_d;
  logic [1:0][XLEN-1:0]     fwd;
  logic [1:0][4:0]          id_rs;
  logic [1:0][XLEN-1:0]     id_rs_data;
  logic                     load_use;

  assign id_rs      = {id_rs2_i, id_rs1_i};
  assign id_rs_data = {id_rs2_data_i, id_rs1_data_i};

  // MEM is the younger producer, so it takes precedence over WB; x0 is hardwired zero.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd[gi] = (rs_q[gi] == 5'd0)                      ? '0         :
                       (mem_we_i && (mem_rd_i == rs_q[gi]))    ? mem_data_i :
                       (wb_we_i  && (wb_rd_i  == rs_q[gi]))    ? wb_data_i  :
                                                                 rs_data_q[gi];
    end
  endgenerate

  assign load_use = valid_q && is_load_q && (rd_q != 5'd0) && id_valid_i && !flush_i &&
                    ((id_rs1_used_i && (id_rs1_i == rd_q)) ||
                     (id_rs2_used_i && (id_rs2_i == rd_q)));

  always_comb begin
    valid_d   = valid_q;
    we_d      = we_q;
    is_load_d = is_load_q;
    rd_d      = rd_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    a_sel_d   = a_sel_q;
    b_sel_d   = b_sel_q;
    alu_op_d  = alu_op_q;
    rs_d      = rs_q;
    rs_data_d = rs_data_q;
    if (stall_i) begin
      // Held operands absorb results retiring meanwhile, or WB data would be lost.
      rs_data_d = fwd;
    end else begin
      rd_d      = id_rd_i;
      pc_d      = id_pc_i;
      imm_d     = id_imm_i;
      a_sel_d   = id_a_sel_i;
      b_sel_d   = id_b_sel_i;
      rs_d      = id_rs;
      rs_data_d = id_rs_data;
      if (flush_i || load_use) begin
        valid_d   = 1'b0;
        we_d      = 1'b0;
        is_load_d = 1'b0;
        alu_op_d  = ALU_XXX;
      end else begin
        valid_d   = id_valid_i;
        we_d      = id_we_i & id_valid_i;
        is_load_d = id_is_load_i;
        alu_op_d  = id_alu_op_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      we_q      <= 1'b0;
      is_load_q <= 1'b0;
      rd_q      <= '0;
      pc_q      <= '0;
      imm_q     <= '0;
      a_sel_q   <= '0;
      b_sel_q   <= '0;
      alu_op_q  <= ALU_XXX;
      rs_q      <= '0;
      rs_data_q <= '0;
    end else begin
      valid_q   <= valid_d;
      we_q      <= we_d;
      is_load_q <= is_load_d;
      rd_q      <= rd_d;
      pc_q      <= pc_d;
      imm_q     <= imm_d;
      a_sel_q   <= a_sel_d;
      b_sel_q   <= b_sel_d;
      alu_op_q  <= alu_op_d;
      rs_q      <= rs_d;
      rs_data_q <= rs_data_d;
    end
  end

  always_comb begin
    case (a_sel_q)
      2'd0:    alu_a_o = fwd[0];
      2'd1:    alu_a_o = pc_q;
      default: alu_a_o = '0;
    endcase
    case (b_sel_q)
      2'd0:    alu_b_o = fwd[1];
      2'd1:    alu_b_o = imm_q;
      2'd2:    alu_b_o = XLEN'(4);
      default: alu_b_o = '0;
    endcase
  end

  assign alu_op_o         = alu_op_q;
  assign ex_valid_o       = valid_q;
  assign ex_rd_o          = rd_q;
  assign ex_we_o          = we_q;
  assign ex_is_load_o     = is_load_q;
  assign ex_pc_o          = pc_q;
  assign ex_store_data_o  = fwd[1];
  assign load_use_stall_o = load_use;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios plus randomized traffic
// compared against a slot-level reference model.
module tb_ex_operand_stage;
  localparam logic [3:0] XXX = 4'hF;

  logic        clk, rst_n;
  logic        id_valid, id_rs1_used, id_rs2_used, id_we, id_is_load;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [1:0]  id_a_sel, id_b_sel;
  logic [3:0]  id_alu_op;
  logic        stall, flush, mem_we, wb_we;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_data, wb_data;
  logic [31:0] alu_a, alu_b, ex_pc, ex_store_data;
  logic [3:0]  alu_op;
  logic        ex_valid, ex_we, ex_is_load, load_use_stall;
  logic [4:0]  ex_rd;

  int checks = 0;
  int errors = 0;

  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid), .id_pc_i(id_pc), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
    .id_rs1_data_i(id_rs1_data), .id_rs2_data_i(id_rs2_data), .id_imm_i(id_imm),
    .id_a_sel_i(id_a_sel), .id_b_sel_i(id_b_sel), .id_alu_op_i(id_alu_op),
    .id_rd_i(id_rd), .id_we_i(id_we), .id_is_load_i(id_is_load),
    .stall_i(stall), .flush_i(flush),
    .mem_we_i(mem_we), .mem_rd_i(mem_rd), .mem_data_i(mem_data),
    .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
    .ex_valid_o(ex_valid), .ex_rd_o(ex_rd), .ex_we_o(ex_we), .ex_is_load_o(ex_is_load),
    .ex_pc_o(ex_pc), .ex_store_data_o(ex_store_data), .load_use_stall_o(load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the instruction currently occupying EX.
  logic        m_valid, m_we, m_ld;
  logic [31:0] m_pc, m_imm, m_d1, m_d2;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [1:0]  m_asel, m_bsel;
  logic [3:0]  m_op;

  function automatic logic [31:0] ref_src(input logic [4:0] src, input logic [31:0] regval);
    if (src == 5'd0) return 32'd0;
    if (mem_we && mem_rd == src) return mem_data;
    if (wb_we && wb_rd == src) return wb_data;
    return regval;
  endfunction

  function automatic logic [31:0] ref_a();
    if (m_asel == 2'd0) return ref_src(m_rs1, m_d1);
    if (m_asel == 2'd1) return m_pc;
    return 32'd0;
  endfunction

  function automatic logic [31:0] ref_b();
    if (m_bsel == 2'd0) return ref_src(m_rs2, m_d2);
    if (m_bsel == 2'd1) return m_imm;
    if (m_bsel == 2'd2) return 32'd4;
    return 32'd0;
  endfunction

  function automatic logic ref_lus();
    if (flush) return 1'b0;
    return m_valid && m_ld && m_rd != 5'd0 && id_valid &&
           ((id_rs1_used && id_rs1 == m_rd) || (id_rs2_used && id_rs2 == m_rd));
  endfunction

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_ld = 0; m_pc = 0; m_imm = 0; m_d1 = 0; m_d2 = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_asel = 0; m_bsel = 0; m_op = XXX;
  endtask

  // Advance the model by the upcoming edge, then move to 1 time unit past that edge.
  task automatic tick();
    logic        lus;
    logic [31:0] f1, f2;
    lus = ref_lus();
    f1  = ref_src(m_rs1, m_d1);
    f2  = ref_src(m_rs2, m_d2);
    if (!rst_n) model_reset();
    else if (stall) begin
      m_d1 = f1; m_d2 = f2;
    end else begin
      m_pc = id_pc; m_imm = id_imm; m_d1 = id_rs1_data; m_d2 = id_rs2_data;
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_asel = id_a_sel; m_bsel = id_b_sel;
      if (flush || lus) begin
        m_valid = 0; m_we = 0; m_ld = 0; m_op = XXX;
      end else begin
        m_valid = id_valid; m_we = id_we & id_valid; m_ld = id_is_load; m_op = id_alu_op;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_a_sel = 0; id_b_sel = 0;
    id_alu_op = 0; id_rd = 0; id_we = 0; id_is_load = 0;
    stall = 0; flush = 0; mem_we = 0; mem_rd = 0; mem_data = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic drive_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                             input logic [1:0] asel, input logic [1:0] bsel, input logic [4:0] rd,
                             input logic we, input logic ld);
    id_valid = 1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = 1; id_rs2_used = 1;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_a_sel = asel; id_b_sel = bsel;
    id_alu_op = 4'd3; id_rd = rd; id_we = we; id_is_load = ld;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #2;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d exp 0", ex_valid); end
    checks++; if (ex_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0d exp 0", ex_we); end
    checks++; if (alu_op !== XXX) begin errors++; $display("FAIL reset_op got %h exp %h", alu_op, XXX); end
    checks++; if (ex_pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp 0", ex_pc); end
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL reset_lus got %0d exp 0", load_use_stall); end
    $display("txn reset: valid=%0d op=%h", ex_valid, alu_op);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_addi();
    drive_instr(32'h40, 5'd0, 5'd0, 32'd0, 32'd0, 32'd7, 2'd0, 2'd1, 5'd5, 1'b1, 1'b0);
    tick();
    id_valid = 0;
    #1;
    checks++; if (alu_a !== 32'd0) begin errors++; $display("FAIL addi_a got %h exp 0", alu_a); end
    checks++; if (alu_b !== 32'd7) begin errors++; $display("FAIL addi_b got %h exp 7", alu_b); end
    checks++; if (ex_we !== 1'b1) begin errors++; $display("FAIL addi_we got %0d exp 1", ex_we); end
    checks++; if (ex_rd !== 5'd5) begin errors++; $display("FAIL addi_rd got %0d exp 5", ex_rd); end
    $display("txn addi: a=%h b=%h we=%0d", alu_a, alu_b, ex_we);
    tick();
  endtask

  task automatic test_forward_priority();
    drive_instr(32'h44, 5'd5, 5'd0, 32'd1, 32'd0, 32'd0, 2'd0, 2'd0, 5'd1, 1'b1, 1'b0);
    tick();
    id_valid = 0;
    mem_we = 1; mem_rd = 5; mem_data = 32'h11; wb_we = 1; wb_rd = 5; wb_data = 32'h22;
    #1;
    checks++; if (alu_a !== 32'h11) begin errors++; $display("FAIL fwd_mem got %h exp 11", alu_a); end
    mem_we = 0;
    #1;
    checks++; if (alu_a !== 32'h22) begin errors++; $display("FAIL fwd_wb got %h exp 22", alu_a); end
    wb_we = 0;
    #1;
    checks++; if (alu_a !== 32'h1) begin errors++; $display("FAIL fwd_reg got %h exp 1", alu_a); end
    $display("txn forward: a=%h", alu_a);
    tick();
  endtask

  task automatic test_x0();
    drive_instr(32'h48, 5'd0, 5'd0, 32'h55, 32'h66, 32'd0, 2'd0, 2'd0, 5'd2, 1'b1, 1'b0);
    tick();
    id_valid = 0;
    mem_we = 1; mem_rd = 0; mem_data = 32'hFFFF; wb_we = 1; wb_rd = 0; wb_data = 32'h1234;
    #1;
    checks++; if (alu_a !== 32'd0) begin errors++; $display("FAIL x0_a got %h exp 0", alu_a); end
    checks++; if (ex_store_data !== 32'd0) begin errors++; $display("FAIL x0_store got %h exp 0", ex_store_data); end
    $display("txn x0: a=%h", alu_a);
    mem_we = 0; wb_we = 0;
    tick();
  endtask

  task automatic test_load_use();
    drive_instr(32'h4C, 5'd1, 5'd0, 32'd0, 32'd0, 32'd8, 2'd0, 2'd1, 5'd6, 1'b1, 1'b1);
    id_rs2_used = 0;
    tick();
    drive_instr(32'h50, 5'd1, 5'd6, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 5'd7, 1'b0, 1'b0);
    #1;
    checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL lu_flag got %0d exp 1", load_use_stall); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble_valid got %0d exp 0", ex_valid); end
    checks++; if (ex_we !== 1'b0) begin errors++; $display("FAIL lu_bubble_we got %0d exp 0", ex_we); end
    checks++; if (ex_is_load !== 1'b0) begin errors++; $display("FAIL lu_bubble_ld got %0d exp 0", ex_is_load); end
    checks++; if (alu_op !== XXX) begin errors++; $display("FAIL lu_bubble_op got %h exp %h", alu_op, XXX); end
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_release got %0d exp 0", load_use_stall); end
    $display("txn load_use: bubble valid=%0d", ex_valid);
    id_valid = 0;
    tick();
  endtask

  task automatic test_stall_refresh();
    drive_instr(32'h54, 5'd1, 5'd7, 32'd0, 32'h10, 32'd0, 2'd0, 2'd0, 5'd3, 1'b0, 1'b0);
    tick();
    id_valid = 0;
    #1;
    checks++; if (ex_store_data !== 32'h10) begin errors++; $display("FAIL st_initial got %h exp 10", ex_store_data); end
    stall = 1; wb_we = 1; wb_rd = 7; wb_data = 32'hABCD;
    tick();
    wb_we = 0;
    #1;
    checks++; if (ex_store_data !== 32'hABCD) begin errors++; $display("FAIL st_cycle2 got %h exp abcd", ex_store_data); end
    tick();
    checks++; if (alu_b !== 32'hABCD) begin errors++; $display("FAIL st_held_b got %h exp abcd", alu_b); end
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL st_held_valid got %0d exp 1", ex_valid); end
    $display("txn stall: store=%h", ex_store_data);
    stall = 0;
    tick();
  endtask

  task automatic test_flush();
    drive_instr(32'h58, 5'd1, 5'd0, 32'd0, 32'd0, 32'd0, 2'd0, 2'd1, 5'd6, 1'b1, 1'b1);
    tick();
    drive_instr(32'h5C, 5'd6, 5'd0, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 5'd4, 1'b1, 1'b0);
    flush = 1;
    #1;
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL fl_lus got %0d exp 0", load_use_stall); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL fl_valid got %0d exp 0", ex_valid); end
    flush = 0;
    drive_instr(32'h100, 5'd1, 5'd2, 32'd0, 32'd0, 32'd0, 2'd1, 2'd2, 5'd9, 1'b1, 1'b0);
    tick();
    drive_instr(32'h200, 5'd1, 5'd2, 32'd0, 32'd0, 32'd0, 2'd1, 2'd2, 5'd9, 1'b1, 1'b0);
    stall = 1; flush = 1;
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL sf_valid got %0d exp 1", ex_valid); end
    checks++; if (ex_pc !== 32'h100) begin errors++; $display("FAIL sf_pc got %h exp 100", ex_pc); end
    checks++; if (alu_a !== 32'h100) begin errors++; $display("FAIL sf_a got %h exp 100", alu_a); end
    $display("txn flush: valid=%0d pc=%h", ex_valid, ex_pc);
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_midstream();
    drive_instr(32'h300, 5'd1, 5'd2, 32'd5, 32'd6, 32'd0, 2'd1, 2'd0, 5'd8, 1'b1, 1'b0);
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL mr_pre got %0d exp 1", ex_valid); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got %0d exp 0", ex_valid); end
    checks++; if (ex_pc !== 32'd0) begin errors++; $display("FAIL mr_pc got %h exp 0", ex_pc); end
    checks++; if (alu_op !== XXX) begin errors++; $display("FAIL mr_op got %h exp %h", alu_op, XXX); end
    model_reset();
    #2 rst_n = 1'b1;
    tick();
    checks++; if (ex_pc !== 32'h300 || ex_valid !== 1'b1) begin errors++; $display("FAIL mr_recap got pc=%h v=%0d exp pc=300 v=1", ex_pc, ex_valid); end
    $display("txn reset_midstream: pc=%h", ex_pc);
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [31:0] ea, eb, es;
    for (int n = 0; n < 300; n++) begin
      id_valid = 1'($urandom_range(0, 3) != 0);
      id_pc = $urandom; id_imm = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom;
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
      id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
      id_a_sel = 2'($urandom); id_b_sel = 2'($urandom); id_alu_op = 4'($urandom);
      id_rd = 5'($urandom_range(0, 7)); id_we = 1'($urandom); id_is_load = 1'($urandom_range(0, 2) == 0);
      stall = 1'($urandom_range(0, 7) == 0); flush = 1'($urandom_range(0, 9) == 0);
      mem_we = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_data = $urandom;
      wb_we = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
      #1;
      ea = ref_a(); eb = ref_b(); es = ref_src(m_rs2, m_d2);
      checks++; if (load_use_stall !== ref_lus()) begin errors++; $display("FAIL rnd%0d_lus got %0d exp %0d", n, load_use_stall, ref_lus()); end
      checks++; if (ex_valid !== m_valid) begin errors++; $display("FAIL rnd%0d_valid got %0d exp %0d", n, ex_valid, m_valid); end
      checks++; if (ex_we !== m_we) begin errors++; $display("FAIL rnd%0d_we got %0d exp %0d", n, ex_we, m_we); end
      checks++; if (ex_is_load !== m_ld) begin errors++; $display("FAIL rnd%0d_ld got %0d exp %0d", n, ex_is_load, m_ld); end
      checks++; if (alu_op !== m_op) begin errors++; $display("FAIL rnd%0d_op got %h exp %h", n, alu_op, m_op); end
      if (m_valid) begin
        checks++; if (ex_rd !== m_rd) begin errors++; $display("FAIL rnd%0d_rd got %0d exp %0d", n, ex_rd, m_rd); end
        checks++; if (ex_pc !== m_pc) begin errors++; $display("FAIL rnd%0d_pc got %h exp %h", n, ex_pc, m_pc); end
        checks++; if (alu_a !== ea) begin errors++; $display("FAIL rnd%0d_a got %h exp %h", n, alu_a, ea); end
        checks++; if (alu_b !== eb) begin errors++; $display("FAIL rnd%0d_b got %h exp %h", n, alu_b, eb); end
        checks++; if (ex_store_data !== es) begin errors++; $display("FAIL rnd%0d_store got %h exp %h", n, ex_store_data, es); end
      end
      $display("txn rnd%0d: st=%0d fl=%0d v=%0d a=%h b=%h lus=%0d", n, stall, flush, ex_valid, alu_a, alu_b, load_use_stall);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_addi();
    test_forward_priority();
    test_x0();
    test_load_use();
    test_stall_refresh();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
